lm07_poll_ctrl: RTL and testbench

//   SPI master and read scheduler for the LM07 temperature sensor.
//   - Generates CS/SCK and shifts in the 16-bit temperature frame on SIO, MSB first.
//   - Triggers a read on a manual start pulse, on a periodic poll timer, or both.
//   - Presents the result as temp_data with a one-cycle temp_valid strobe to the system side.

---
 rtl/lm07_poll_ctrl.sv | 120 ++++++++++++
 tb/tb_lm07_poll_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lm07_poll_ctrl.sv
// lm07_poll_ctrl: SPI master and read scheduler for the LM07 sensor; optional alarm via LM07_ALARM_EN
module lm07_poll_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int POLL_PERIOD = 1000,
  parameter int FRAME_BITS  = 16
) (
  input  logic                  SYSCLK,
  input  logic                  RSTN,
  input  logic                  start,
  input  logic                  poll_en,
  output logic                  CS,
  output logic                  SCK,
  input  logic                  SIO,
  output logic [FRAME_BITS-1:0] temp_data,
  output logic                  temp_valid,
  output logic                  busy,
  input  logic [7:0]            hi_limit,
  input  logic                  alarm_clr,
  output logic                  alarm
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
  localparam int PW = POLL_PERIOD > 1 ? $clog2(POLL_PERIOD) : 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SCK_HI = 3'd2;
  localparam logic [2:0] SCK_LO = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] GAP    = 3'd5;
  logic [2:0]            state;
  logic [DW-1:0]         div;
  logic [BW-1:0]         bits;
  logic [PW-1:0]         pcnt;
  logic                  pending;
  logic [FRAME_BITS-1:0] shift;
  logic                  tick, div_end, leave;
  assign tick    = poll_en && pcnt == PW'(POLL_PERIOD - 1);
  assign div_end = div == DW'(CLK_DIV - 1);
  assign leave   = state == IDLE && (pending || start);
  // free-running poll timer, held at 0 while polling is disabled
  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) pcnt <= '0;
    else pcnt <= (!poll_en || tick) ? '0 : pcnt + 1'b1;
  // single request slot; extra requests coalesce until the FSM leaves IDLE
  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) pending <= 1'b0;
    else pending <= leave ? 1'b0 : (pending | start | tick);
  // phase timer: every non-idle state lasts CLK_DIV cycles
  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) div <= '0;
    else div <= (state == IDLE || div_end) ? '0 : div + 1'b1;
  // frame sequencer: SCK rise edge also samples SIO
  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) begin
      state      <= IDLE;
      CS         <= 1'b1;
      SCK        <= 1'b0;
      busy       <= 1'b0;
      bits       <= '0;
      shift      <= '0;
      temp_data  <= '0;
      temp_valid <= 1'b0;
    end else begin
      temp_valid <= 1'b0;
      case (state)
        IDLE:
          if (leave) begin
            state <= SETUP;
            CS    <= 1'b0;
            busy  <= 1'b1;
            bits  <= '0;
          end
        SETUP:
          if (div_end) begin
            state <= SCK_HI;
            SCK   <= 1'b1;
            shift <= {shift[FRAME_BITS-2:0], SIO};
          end
        SCK_HI:
          if (div_end) begin
            state <= SCK_LO;
            SCK   <= 1'b0;
          end
        SCK_LO:
          if (div_end) begin
            bits <= bits + 1'b1;
            if (bits == BW'(FRAME_BITS - 1)) state <= HOLD;
            else begin
              state <= SCK_HI;
              SCK   <= 1'b1;
              shift <= {shift[FRAME_BITS-2:0], SIO};
            end
          end
        HOLD:
          if (div_end) begin
            state      <= GAP;
            CS         <= 1'b1;
            temp_data  <= shift;
            temp_valid <= 1'b1;
          end
        GAP:
          if (div_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
`ifdef LM07_ALARM_EN
  // sticky over-temperature flag; a new set beats a simultaneous clear
  always_ff @(posedge SYSCLK or negedge RSTN)
    if (!RSTN) alarm <= 1'b0;
    else if (temp_valid && $signed(temp_data[FRAME_BITS-1-:8]) > $signed(hi_limit)) alarm <= 1'b1;
    else if (alarm_clr) alarm <= 1'b0;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = ^{hi_limit, alarm_clr};
  assign alarm = 1'b0;
`endif
endmodule

// File: tb/tb_lm07_poll_ctrl.sv
// tb_lm07_poll_ctrl: randomized and directed checks against a frame-timeline model of the poll controller
module tb_lm07_poll_ctrl;
  localparam int D   = 2;
  localparam int FB  = 16;
  localparam int P   = 200;
  localparam int CSL = (2 * FB + 2) * D;
  logic SYSCLK = 0, RSTN = 0, start = 0, poll_en = 0, SIO = 0, alarm_clr = 0;
  logic [7:0] hi_limit = 8'h7f;
  logic CS, SCK, temp_valid, busy, alarm;
  logic [15:0] temp_data;
  logic [15:0] temp_set = 16'h4400;
  int checks = 0, errors = 0;
  lm07_poll_ctrl #(.CLK_DIV(D), .POLL_PERIOD(P), .FRAME_BITS(FB)) dut (
    .SYSCLK(SYSCLK), .RSTN(RSTN), .start(start), .poll_en(poll_en), .CS(CS), .SCK(SCK),
    .SIO(SIO), .temp_data(temp_data), .temp_valid(temp_valid), .busy(busy),
    .hi_limit(hi_limit), .alarm_clr(alarm_clr), .alarm(alarm));
  always #5 SYSCLK = ~SYSCLK;
  // sensor: latches its reading at CS fall, presents MSB first, shifts on SCK fall
  logic [15:0] sens;
  int idx;
  always @(negedge CS) begin
    sens = temp_set;
    idx = FB - 1;
    SIO = sens[idx];
  end
  always @(negedge SCK)
    if (!CS && idx > 0) begin
      idx--;
      SIO = sens[idx];
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: a frame is a timeline k = 1.. after the edge that leaves idle
  bit m_active, m_pend, m_alarm;
  int m_k, m_pcnt;
  logic [15:0] m_td, m_fval;
  task automatic model_step();
    bit tick, tv_now;
    if (!RSTN) begin
      m_active = 0; m_pend = 0; m_alarm = 0; m_k = 0; m_pcnt = 0; m_td = 0;
      return;
    end
    tick = poll_en && m_pcnt == P - 1;
    m_pcnt = (!poll_en || tick) ? 0 : m_pcnt + 1;
    tv_now = m_active && m_k == CSL + 1;
`ifdef LM07_ALARM_EN
    if (tv_now && $signed(m_td[15:8]) > $signed(hi_limit)) m_alarm = 1;
    else if (alarm_clr) m_alarm = 0;
`endif
    if (m_active) begin
      m_pend = m_pend | start | tick;
      m_k++;
      if (m_k == CSL + 1) m_td = m_fval;
      if (m_k > CSL + D) m_active = 0;
    end else if (m_pend || start) begin
      m_active = 1; m_k = 1; m_pend = 0; m_fval = temp_set;
    end else m_pend = tick;
  endtask
  // frame monitor state used by the directed checks
  int cyc = 0, cs_low = 0, last_low = 0, sck_rises = 0, nf = 0, last_rise = 0, high_gap = 0;
  int fall_t[$];
  logic prev_cs = 1, prev_sck = 0;
  always @(posedge SYSCLK) begin
    bit e_sck;
    model_step();
    #1;
    e_sck = m_active && m_k > D && m_k <= D + 2 * D * FB && ((m_k - D - 1) % (2 * D) < D);
    chk("CS", CS, !(m_active && m_k <= CSL));
    chk("SCK", SCK, e_sck);
    chk("busy", busy, m_active);
    chk("temp_valid", temp_valid, m_active && m_k == CSL + 1);
    chk("temp_data", temp_data, m_td);
    chk("alarm", alarm, m_alarm);
    cyc++;
    if (!CS) cs_low++;
    if (prev_cs && !CS) begin
      fall_t.push_back(cyc); nf++; sck_rises = 0; high_gap = cyc - last_rise;
    end
    if (!prev_cs && CS) begin
      last_low = cs_low; cs_low = 0; last_rise = cyc;
    end
    if (!prev_sck && SCK) sck_rises++;
    prev_cs = CS;
    prev_sck = SCK;
  end
  task automatic pulse_start();
    @(negedge SYSCLK) start = 1;
    @(negedge SYSCLK) start = 0;
  endtask
  task automatic wait_tv(input int n);
    bit seen = 0;
    for (int i = 0; i < n && !seen; i++) begin
      @(negedge SYSCLK);
      seen = temp_valid;
    end
    chk("tv_timeout", seen, 1);
  endtask
  initial begin
    int base;
    repeat (3) @(negedge SYSCLK);
    chk("rst_CS", CS, 1);
    chk("rst_SCK", SCK, 0);
    chk("rst_temp_data", temp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_temp_valid", temp_valid, 0);
    chk("rst_alarm", alarm, 0);
    RSTN = 1;
    repeat (2) @(negedge SYSCLK);
    pulse_start();
    wait_tv(200);
    chk("single_data", temp_data, 16'h4400);
    chk("cs_low_len", last_low, 68);
    chk("sck_rises", sck_rises, 16);
    @(negedge SYSCLK) chk("busy_after_1", busy, 1);
    @(negedge SYSCLK) chk("busy_after_2", busy, 0);
    base = nf;
    poll_en = 1;
    for (int i = 0; i < 900 && nf < base + 3; i++) @(negedge SYSCLK);
    chk("poll_frames", nf - base >= 3, 1);
    if (fall_t.size() >= 3) begin
      chk("poll_period_a", fall_t[base + 1] - fall_t[base], 200);
      chk("poll_period_b", fall_t[base + 2] - fall_t[base + 1], 200);
    end
    poll_en = 0;
    repeat (100) @(negedge SYSCLK);
    chk("poll_data", temp_data, 16'h4400);
    base = nf;
    pulse_start();
    repeat (10) @(negedge SYSCLK);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      repeat (5) @(negedge SYSCLK);
    end
    repeat (200) @(negedge SYSCLK);
    chk("coalesce_frames", nf - base, 2);
    chk("b2b_gap", high_gap, D + 1);
    pulse_start();
    for (int i = 0; i < 100 && sck_rises < 5; i++) @(negedge SYSCLK);
    chk("five_rises", sck_rises, 5);
    RSTN = 0;
    #1;
    chk("abort_CS", CS, 1);
    chk("abort_temp_data", temp_data, 0);
    @(negedge SYSCLK) RSTN = 1;
    pulse_start();
    wait_tv(200);
    chk("after_abort_data", temp_data, 16'h4400);
`ifdef LM07_ALARM_EN
    hi_limit = 8'h40;
    pulse_start();
    wait_tv(200);
    @(negedge SYSCLK) chk("alarm_set", alarm, 1);
    alarm_clr = 1;
    @(negedge SYSCLK) alarm_clr = 0;
    chk("alarm_clr", alarm, 0);
    hi_limit = 8'h50;
    pulse_start();
    wait_tv(200);
    @(negedge SYSCLK) chk("alarm_quiet", alarm, 0);
`endif
    repeat (100) @(negedge SYSCLK);
    for (int i = 0; i < 6000; i++) begin
      @(negedge SYSCLK);
      start = $urandom_range(39) == 0;
      if ($urandom_range(299) == 0) poll_en = ~poll_en;
      if (CS) temp_set = 16'($urandom);
      if ($urandom_range(99) == 0) hi_limit = 8'($urandom);
      alarm_clr = $urandom_range(49) == 0;
      RSTN = $urandom_range(1499) != 0;
    end
    @(negedge SYSCLK) begin start = 0; RSTN = 1; end
    repeat (5) @(negedge SYSCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
